// File: rtl/alu_seq_ctrl.sv
// Multi-cycle sequencer in front of a 32-bit combinational ALU: latches a request,
// runs one or two ALU passes, merges flags into the NZCV register, returns the result.
module alu_seq_ctrl #(
  parameter logic [3:0] FLAG_RESET = 4'b0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        reqValid,
  output logic        reqReady,
  input  logic [1:0]  reqOp,
  input  logic        reqWide,
  input  logic        reqUseCarry,
  input  logic        reqSetFlags,
  input  logic [63:0] reqA,
  input  logic [63:0] reqB,
  output logic [31:0] aluIn1,
  output logic [31:0] aluIn2,
  output logic        aluCarry,
  output logic [1:0]  aluOp,
  input  logic [31:0] aluOut,
  input  logic        aluN,
  input  logic        aluZ,
  input  logic        aluC,
  input  logic        aluV,
  output logic        rspValid,
  input  logic        rspReady,
  output logic [63:0] rspData,
  output logic [3:0]  rspFlags,
  output logic [3:0]  flags,
  output logic [1:0]  dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are both
  // high; a valid source holds its payload stable until that edge.

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_LO = 2'd1, S_HI = 2'd2, S_RESP = 2'd3} state_t;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_AND = 2'b10;
  localparam logic [1:0] OP_ROR = 2'b11;

  state_t      state_q, state_d;
  logic [1:0]  op_q, op_d;
  logic        wide_q, wide_d;
  logic        use_carry_q, use_carry_d;
  logic        set_flags_q, set_flags_d;
  logic [63:0] a_q, a_d;
  logic [63:0] b_q, b_d;
  logic [31:0] res_lo_q, res_lo_d;
  logic [31:0] res_hi_q, res_hi_d;
  logic        z_lo_q, z_lo_d;
  logic        c_lo_q, c_lo_d;
  logic [3:0]  rsp_flags_q, rsp_flags_d;
  logic [3:0]  flags_q, flags_d;

  logic        z_eff;
  logic [3:0]  merged;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      op_q        <= 2'b00;
      wide_q      <= 1'b0;
      use_carry_q <= 1'b0;
      set_flags_q <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      res_lo_q    <= '0;
      res_hi_q    <= '0;
      z_lo_q      <= 1'b0;
      c_lo_q      <= 1'b0;
      rsp_flags_q <= 4'b0000;
      flags_q     <= FLAG_RESET;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      wide_q      <= wide_d;
      use_carry_q <= use_carry_d;
      set_flags_q <= set_flags_d;
      a_q         <= a_d;
      b_q         <= b_d;
      res_lo_q    <= res_lo_d;
      res_hi_q    <= res_hi_d;
      z_lo_q      <= z_lo_d;
      c_lo_q      <= c_lo_d;
      rsp_flags_q <= rsp_flags_d;
      flags_q     <= flags_d;
    end
  end

  // Flags of the pass finishing this cycle; a wide result is zero only if both halves are.
  always_comb begin
    z_eff = (state_q == S_HI) ? (z_lo_q & aluZ) : aluZ;
    unique case (op_q)
      OP_ADD, OP_SUB: merged = {aluN, z_eff, aluC, aluV};
      OP_AND:         merged = {aluN, aluZ, flags_q[1], flags_q[0]};
      default:        merged = {aluN, aluZ, aluC, flags_q[0]};
    endcase
  end

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    wide_d      = wide_q;
    use_carry_d = use_carry_q;
    set_flags_d = set_flags_q;
    a_d         = a_q;
    b_d         = b_q;
    res_lo_d    = res_lo_q;
    res_hi_d    = res_hi_q;
    z_lo_d      = z_lo_q;
    c_lo_d      = c_lo_q;
    rsp_flags_d = rsp_flags_q;
    flags_d     = flags_q;
    unique case (state_q)
      S_IDLE: begin
        if (reqValid) begin
          op_d        = reqOp;
          wide_d      = reqWide & ~reqOp[1];
          use_carry_d = reqUseCarry;
          set_flags_d = reqSetFlags;
          a_d         = reqA;
          b_d         = reqB;
          res_hi_d    = '0;
          state_d     = S_LO;
        end
      end
      S_LO: begin
        res_lo_d = aluOut;
        z_lo_d   = aluZ;
        c_lo_d   = aluC;
        if (wide_q) begin
          state_d = S_HI;
        end else begin
          rsp_flags_d = merged;
          if (set_flags_q) flags_d = merged;
          state_d = S_RESP;
        end
      end
      S_HI: begin
        res_hi_d    = aluOut;
        rsp_flags_d = merged;
        if (set_flags_q) flags_d = merged;
        state_d = S_RESP;
      end
      default: begin
        if (rspReady) state_d = S_IDLE;
      end
    endcase
  end

  // Wide SUB is computed as B + ~A + 1 through the adder so the carry chains across halves.
  always_comb begin
    aluIn1   = '0;
    aluIn2   = '0;
    aluCarry = 1'b0;
    aluOp    = OP_ADD;
    if (state_q == S_LO) begin
      aluIn2 = b_q[31:0];
      unique case (op_q)
        OP_ADD: begin
          aluIn1   = a_q[31:0];
          aluCarry = use_carry_q & flags_q[1];
        end
        OP_SUB: begin
          if (wide_q) begin
            aluIn1   = ~a_q[31:0];
            aluCarry = 1'b1;
          end else begin
            aluIn1 = a_q[31:0];
            aluOp  = OP_SUB;
          end
        end
        OP_AND: begin
          aluIn1 = a_q[31:0];
          aluOp  = OP_AND;
        end
        default: begin
          aluIn1 = {27'b0, a_q[4:0]};
          aluOp  = OP_ROR;
        end
      endcase
    end else if (state_q == S_HI) begin
      aluIn1   = (op_q == OP_SUB) ? ~a_q[63:32] : a_q[63:32];
      aluIn2   = b_q[63:32];
      aluCarry = c_lo_q;
    end
  end

  assign reqReady  = (state_q == S_IDLE);
  assign rspValid  = (state_q == S_RESP);
  assign rspData   = {res_hi_q, res_lo_q};
  assign rspFlags  = rsp_flags_q;
  assign flags     = flags_q;
  assign dbg_state = state_q;

endmodule
